// File: rtl/mux8_lane_sequencer.sv
// -----------------------------------------------------------------------------
// mux8_lane_sequencer
//
// Upstream controller for an 8:1 byte-lane mux. It accepts a word plus a
// per-lane enable mask, holds the word on the mux data bus, and steps the lane
// select through every enabled lane in ascending order. Each lane is released
// downstream under its own valid/ready handshake, so the combinational mux
// becomes a word-to-byte serializer.
//
// Build option:
//   MUX8_LANE_SEQ_BACK2BACK_EN - when defined, a new word can be accepted on
//   the same edge as the final lane transfer of the current word. The next
//   word's first lane then follows with no idle cycle. When undefined, words
//   are separated by exactly one idle cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   upstream word valid
//   in_ready   out  block can accept a word
//   in_data    in   word; lane k is in_data[k*LANE_W +: LANE_W]
//   in_mask    in   lane enables; bit k=1 emits lane k
//   word       out  registered copy of the accepted word (mux data input)
//   sel        out  3-bit lane select to the mux
//   out_valid  out  current sel/word lane is valid
//   out_ready  in   downstream consumed the lane
//   out_last   out  current lane is the highest enabled lane of the word
//   empty_drop out  one-cycle pulse: a word with in_mask==0 was discarded
// -----------------------------------------------------------------------------
module mux8_lane_sequencer #(
  parameter int LANE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*LANE_W-1:0] in_data,
  input  logic [7:0]          in_mask,
  output logic [8*LANE_W-1:0] word,
  output logic [2:0]          sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                empty_drop
);

  localparam int WORD_W = 8 * LANE_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [WORD_W-1:0] word_n;
  logic [2:0]        sel_n;
  logic [7:0]        pend, pend_n;
  logic              last_n;
  logic              drop_n;

  logic              accept;
  logic              xfer;
  logic              word_done;
  logic [7:0]        remaining;

  // Index of the lowest enabled lane; 0 for an empty mask (never used then).
  function automatic logic [2:0] lowest_lane(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  // True when exactly one lane is enabled, i.e. the lowest lane is also last.
  function automatic logic single_lane(input logic [7:0] m);
    return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
  endfunction

  assign out_valid = (state == EMIT);
  assign xfer      = out_valid && out_ready;
  assign word_done = xfer && out_last;

`ifdef MUX8_LANE_SEQ_BACK2BACK_EN
  // The final lane transfer frees the word register on the same edge, so a
  // new word may be captured alongside it.
  assign in_ready = !rst && ((state == IDLE) || word_done);
`else
  assign in_ready = !rst && (state == IDLE);
`endif

  assign accept = in_valid && in_ready;

  // Pending mask always includes the lane currently presented; clearing it
  // leaves only higher lanes, so the lowest remaining bit is the next lane and
  // the select can never wrap within a word.
  assign remaining = pend & ~(8'b1 << sel);

  always_comb begin
    state_n = state;
    word_n  = word;
    sel_n   = sel;
    pend_n  = pend;
    last_n  = out_last;
    drop_n  = 1'b0;

    if (xfer) begin
      if (remaining != 8'd0) begin
        sel_n  = lowest_lane(remaining);
        last_n = single_lane(remaining);
        pend_n = remaining;
      end else begin
        state_n = IDLE;
        pend_n  = 8'd0;
        last_n  = 1'b0;
      end
    end

    // Accept overrides the end-of-word update above when both happen together.
    if (accept) begin
      word_n = in_data;
      pend_n = in_mask;
      if (in_mask != 8'd0) begin
        state_n = EMIT;
        sel_n   = lowest_lane(in_mask);
        last_n  = single_lane(in_mask);
      end else begin
        state_n = IDLE;
        last_n  = 1'b0;
        drop_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word       <= '0;
      sel        <= 3'd0;
      pend       <= 8'd0;
      out_last   <= 1'b0;
      empty_drop <= 1'b0;
    end else begin
      state      <= state_n;
      word       <= word_n;
      sel        <= sel_n;
      pend       <= pend_n;
      out_last   <= last_n;
      empty_drop <= drop_n;
    end
  end

endmodule

// File: tb/tb_mux8_lane_sequencer.sv
module tb_mux8_lane_sequencer;

  localparam int LANE_W = 8;
  localparam int WORD_W = 8 * LANE_W;
`ifdef MUX8_LANE_SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [7:0]        in_mask;
  logic [WORD_W-1:0] word;
  logic [2:0]        sel;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              empty_drop;

  mux8_lane_sequencer #(.LANE_W(LANE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .word      (word),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .empty_drop(empty_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]        lsel;
    logic [LANE_W-1:0] lane;
    logic              last;
    logic [WORD_W-1:0] wrd;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   xfers = 0;
  bit   drop_due = 1'b0;
  bit   post_rst = 1'b0;
  bit   rdy_rand = 1'b0;

  task automatic check(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word expands into one entry per enabled lane, in
  // ascending lane order; the last entry is the highest enabled lane.
  task automatic model_push(input logic [WORD_W-1:0] d, input logic [7:0] m);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        e.lsel = 3'(k);
        e.lane = d[k*LANE_W +: LANE_W];
        e.last = ((m >> (k + 1)) == 8'd0);
        e.wrd  = d;
        q.push_back(e);
      end
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    bit exp_rdy;
    if (rst) begin
      check("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
      q.delete();
      drop_due = 1'b0;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        check("rst_sel", {61'd0, sel}, 64'd0);
        check("rst_word", word, 64'd0);
        check("rst_last", {63'd0, out_last}, 64'd0);
        post_rst = 1'b0;
      end
      check("out_valid", {63'd0, out_valid}, {63'd0, (q.size() != 0)});
      check("empty_drop", {63'd0, empty_drop}, {63'd0, drop_due});
      exp_rdy = (q.size() == 0) || (B2B && q.size() == 1 && out_ready);
      check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      if (out_valid && q.size() != 0) begin
        check("sel", {61'd0, sel}, {61'd0, q[0].lsel});
        check("lane", {56'd0, word[sel*LANE_W +: LANE_W]}, {56'd0, q[0].lane});
        check("out_last", {63'd0, out_last}, {63'd0, q[0].last});
        check("word_stable", word, q[0].wrd);
        if (out_ready) begin
          void'(q.pop_front());
          xfers++;
        end
      end
      drop_due = 1'b0;
      if (in_valid && in_ready) begin
        model_push(in_data, in_mask);
        if (in_mask == 8'd0) drop_due = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d, input logic [7:0] m);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no accept required accept mask %h", m);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (q.size() == 0 && out_valid == 1'b0) done = 1'b1;
      else tick();
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL drain_timeout: got %0d lanes pending required 0", q.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int xbase;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = 8'd0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Full mask
    out_ready = 1'b1;
    send_word(64'h8877665544332211, 8'hFF);
    drain();

    // Sparse mask with downstream stalls
    send_word(64'hF0E0D0C0B0A09080, 8'b1010_0100);
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b1; tick();
    drain();

    // Empty mask
    send_word(64'h0123456789ABCDEF, 8'h00);
    tick();
    tick();
    drain();

    // Back-to-back words with in_valid held high
    send_word(64'h1111111111111111, 8'h81);
    send_word(64'h2222222222222222, 8'h01);
    drain();

    // Reset mid-word after the third lane
    xbase = xfers;
    send_word(64'hA7A6A5A4A3A2A1A0, 8'hFF);
    for (int i = 0; i < 50 && xfers < xbase + 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send_word(64'h5A5A5A5A5A5A5A5A, 8'b0011_0000);
    drain();

    // Randomized words, masks, gaps and downstream back-pressure
    rdy_rand = 1'b1;
    for (int w = 0; w < 80; w++) begin
      logic [7:0] m;
      int r;
      repeat ($urandom_range(0, 2)) tick();
      r = $urandom_range(0, 9);
      if (r == 0)      m = 8'h00;
      else if (r == 1) m = 8'hFF;
      else if (r == 2) m = 8'h80;
      else             m = 8'($urandom);
      send_word({$urandom, $urandom}, m);
      if ($urandom_range(0, 3) == 0) begin
        // occasional back-to-back pair without a gap
        send_word({$urandom, $urandom}, 8'($urandom));
      end
    end
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    drain();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
